// File: rtl/power_pkg.sv
// Shared state encoding, idle mux select and rail pass rule for the power sequencer.
package power_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_CHECK    = 3'd1,
        ST_ON       = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_LOCKOUT  = 3'd4
    } pwr_state_t;

    localparam logic [2:0] SEL_IDLE = 3'b111;

    // Even rails must read high, odd rails must read low.
    function automatic logic expected_level(input logic [2:0] chan);
        return ~chan[0];
    endfunction

endpackage

// File: rtl/pm_timer.sv
// Loadable down-counter: after a load of V, o_done is high for one cycle V cycles later
// (on the (V+1)-th cycle after the load edge), then the timer idles until reloaded.
module pm_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;
    logic             r_armed;

    // Count down from the loaded value; disarm once zero has been reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {WIDTH{1'b0}};
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_armed <= 1'b1;
        end else if (r_armed) begin
            if (r_count == {WIDTH{1'b0}}) begin
                r_armed <= 1'b0;
            end else begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign o_done = r_armed && (r_count == {WIDTH{1'b0}});

endmodule

// File: rtl/power_sequencer.sv
// Rail-check sequencer: walks the monitor mux through every rail before closing the kill
// switch, rescans while powered, and retries with cooldown before locking out on faults.
module power_sequencer #(
    parameter int NUM_CHANNELS    = 7,
    parameter int SETTLE_CYCLES   = 1024,
    parameter int COOLDOWN_CYCLES = 25_000_000,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_on_req,
    input  logic       power_off_req,
    input  logic       clear_fault,
    input  logic       data,
    output logic [2:0] sel,
    output logic       kill_sw,
    output logic [2:0] state,
    output logic       fault,
    output logic [2:0] fault_chan,
    output logic [1:0] retry_cnt
);
    import power_pkg::*;

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int COOL_W   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [COOL_W-1:0]   COOL_LOAD   = COOL_W'(COOLDOWN_CYCLES - 1);
    localparam logic [2:0]          LAST_CHAN   = 3'(NUM_CHANNELS - 1);

    pwr_state_t r_state;
    logic [2:0] r_sel;
    logic [2:0] r_chan;
    logic [2:0] r_fault_chan;
    logic       r_kill_sw;
    logic       r_fault;
    logic [1:0] r_retry_cnt;

    logic       w_scan;
    logic       w_pass;
    logic       w_settle_done;
    logic       w_cool_done;
    logic       w_start_check;
    logic       w_settle_load;
    logic       w_cool_load;
    logic [1:0] w_retry_next;
    logic       w_lock_next;

    assign w_scan        = (r_state == ST_CHECK) || (r_state == ST_ON);
    assign w_pass        = (data == expected_level(r_chan));
    assign w_start_check = ((r_state == ST_OFF) && power_on_req) ||
                           ((r_state == ST_COOLDOWN) && w_cool_done);
    // Reloading on every sample restarts the settle window on each sel change; stray loads
    // outside scanning are harmless because the FSM ignores timer events there.
    assign w_settle_load = (w_scan && w_settle_done) || w_start_check;
    assign w_cool_load   = w_scan && w_settle_done && !w_pass;
    assign w_retry_next  = r_retry_cnt + 2'd1;
    assign w_lock_next   = (32'(w_retry_next) >= MAX_RETRIES);

    pm_timer #(.WIDTH(SETTLE_W)) u_settle (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_settle_load),
        .i_load_val (SETTLE_LOAD),
        .o_done     (w_settle_done)
    );

    pm_timer #(.WIDTH(COOL_W)) u_cooldown (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cool_load),
        .i_load_val (COOL_LOAD),
        .o_done     (w_cool_done)
    );

    // Sequencer FSM with registered mux select, kill switch and fault bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_OFF;
            r_sel        <= SEL_IDLE;
            r_chan       <= 3'd0;
            r_kill_sw    <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_chan <= 3'd0;
            r_retry_cnt  <= 2'd0;
        end else if (power_off_req && (r_state != ST_LOCKOUT)) begin
            r_state     <= ST_OFF;
            r_sel       <= SEL_IDLE;
            r_chan      <= 3'd0;
            r_kill_sw   <= 1'b0;
            r_retry_cnt <= 2'd0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (clear_fault) r_fault <= 1'b0;
                    if (power_on_req) begin
                        r_state <= ST_CHECK;
                        r_chan  <= 3'd0;
                        r_sel   <= 3'd0;
                    end
                end
                ST_CHECK, ST_ON: begin
                    if (w_settle_done && !w_pass) begin
                        r_kill_sw    <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_chan <= r_chan;
                        r_retry_cnt  <= w_retry_next;
                        r_sel        <= SEL_IDLE;
                        r_chan       <= 3'd0;
                        r_state      <= w_lock_next ? ST_LOCKOUT : ST_COOLDOWN;
                    end else begin
                        if (clear_fault) r_fault <= 1'b0;
                        if (w_settle_done) begin
                            if (r_chan == LAST_CHAN) begin
                                r_chan <= 3'd0;
                                r_sel  <= 3'd0;
                                if (r_state == ST_CHECK) begin
                                    r_state   <= ST_ON;
                                    r_kill_sw <= 1'b1;
                                end else begin
                                    r_retry_cnt <= 2'd0;
                                end
                            end else begin
                                r_chan <= r_chan + 3'd1;
                                r_sel  <= r_chan + 3'd1;
                            end
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (clear_fault) r_fault <= 1'b0;
                    if (w_cool_done) begin
                        r_state <= ST_CHECK;
                        r_chan  <= 3'd0;
                        r_sel   <= 3'd0;
                    end
                end
                ST_LOCKOUT: begin
                    if (clear_fault) begin
                        r_state     <= ST_OFF;
                        r_fault     <= 1'b0;
                        r_retry_cnt <= 2'd0;
                    end
                end
                default: begin
                    r_state   <= ST_OFF;
                    r_sel     <= SEL_IDLE;
                    r_kill_sw <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign kill_sw    = r_kill_sw;
    assign state      = r_state;
    assign fault      = r_fault;
    assign fault_chan = r_fault_chan;
    assign retry_cnt  = r_retry_cnt;

endmodule
